// File: rtl/serial_adder_if.sv
// Bus for the bit-serial adder: the operand request and the result outputs.
// The master raises start with A/B/Cin valid. The slave accepts it only on an edge where busy=0 and done=0 (IDLE).
// done marks a new Sum/Cout for one cycle. Sum and Cout then hold until the next done.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, with the carry held in a flop.
// The result is published with a one-cycle done pulse after WIDTH shift cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder_if.slave    bus,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_s;
  logic             cell_ca;

  // Full-adder cell on the operand LSBs and the carry flop.
  assign cell_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign cell_ca = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = cell_ca;
        cnt_d   = cnt_q + 1'b1;
        // Final bit: publish the completed word, never a partial one.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {cell_s, res_q[WIDTH-1:1]};
          cout_d  = cell_ca;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.Sum   = sum_q;
  assign bus.Cout  = cout_q;
  assign state_dbg = state_q;
endmodule
